input_debounce_8ch: RTL and testbench

- Upstream conditioning stage for the 8-bit priority encoder / 7-segment decoder.
- Takes 8 raw, asynchronous, bouncy switch or button inputs and synchronises each into the clock domain.
- Debounces each bit independently and presents a clean, registered data byte to the encoder's data input.
- Also flags when that byte is trustworthy after reset and when it changes.

---
 rtl/input_debounce_8ch.sv | 108 ++++++++++
 tb/tb_input_debounce_8ch.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/input_debounce_8ch.sv
// input_debounce_8ch: synchronises and debounces 8 raw switch inputs into a
// clean registered byte for the priority encoder, with settle and change flags.
module input_debounce_8ch #(
  parameter int unsigned TICK_DIV     = 1000,
  parameter int unsigned STABLE_COUNT = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] data_in,
  output logic [7:0] data,
  output logic       valid,
  output logic       changed
);

  localparam int unsigned NBITS = 8;
  localparam int unsigned DIV_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int unsigned CNT_W = $clog2(STABLE_COUNT + 1);

  localparam logic [DIV_W-1:0] DIV_LAST   = DIV_W'(TICK_DIV - 1);
  localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(STABLE_COUNT - 1);
  localparam logic [CNT_W-1:0] SETTLE_MAX = CNT_W'(STABLE_COUNT);

  logic [NBITS-1:0]            sync1_q, sync1_d;
  logic [NBITS-1:0]            sync2_q, sync2_d;
  logic [DIV_W-1:0]            div_q, div_d;
  logic [NBITS-1:0][CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0]            settle_q, settle_d;
  logic [NBITS-1:0]            data_q, data_d;
  logic                        valid_q, valid_d;
  logic                        changed_q, changed_d;
  logic                        tick_c;

  // Sample tick: last cycle of each divider period.
  assign tick_c = (div_q == DIV_LAST);

  // Two-stage synchroniser, straight wire between stages.
  always_comb begin
    sync1_d = data_in;
    sync2_d = sync1_q;
  end

  // Divider, settle counter and per-bit debounce counters.
  always_comb begin
    div_d     = div_q;
    settle_d  = settle_q;
    valid_d   = valid_q;
    data_d    = data_q;
    cnt_d     = cnt_q;
    changed_d = 1'b0;

    if (tick_c) begin
      div_d = '0;
    end else begin
      div_d = div_q + DIV_W'(1);
    end

    if (tick_c) begin
      if (settle_q != SETTLE_MAX) begin
        settle_d = settle_q + CNT_W'(1);
      end
      if (settle_q == CNT_LAST) begin
        valid_d = 1'b1;
      end
      // A bit flips only after STABLE_COUNT consecutive disagreeing ticks.
      for (int i = 0; i < NBITS; i++) begin
        if (sync2_q[i] == data_q[i]) begin
          cnt_d[i] = '0;
        end else if (cnt_q[i] == CNT_LAST) begin
          data_d[i] = sync2_q[i];
          cnt_d[i]  = '0;
        end else begin
          cnt_d[i] = cnt_q[i] + CNT_W'(1);
        end
      end
    end

    // One pulse per updating edge, however many bits flip together.
    changed_d = (data_d != data_q);
  end

  // State registers, asynchronously cleared.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q   <= '0;
      sync2_q   <= '0;
      div_q     <= '0;
      cnt_q     <= '0;
      settle_q  <= '0;
      data_q    <= '0;
      valid_q   <= 1'b0;
      changed_q <= 1'b0;
    end else begin
      sync1_q   <= sync1_d;
      sync2_q   <= sync2_d;
      div_q     <= div_d;
      cnt_q     <= cnt_d;
      settle_q  <= settle_d;
      data_q    <= data_d;
      valid_q   <= valid_d;
      changed_q <= changed_d;
    end
  end

  assign data    = data_q;
  assign valid   = valid_q;
  assign changed = changed_q;

endmodule

// File: tb/tb_input_debounce_8ch.sv
// tb_input_debounce_8ch: directed table plus hand-written corner sequences.
module tb_input_debounce_8ch;

  localparam int TD = 4;
  localparam int SC = 3;

  typedef struct {
    logic [7:0] din;
    int         hold;
    logic [7:0] exp_data;
    int         exp_pulses;
  } vec_t;

  logic       clk;
  logic       rst;
  logic [7:0] din_a, din_b;
  logic [7:0] data_a, data_b;
  logic       valid_a, valid_b;
  logic       changed_a, changed_b;

  int checks;
  int errors;
  int cyc;

  input_debounce_8ch #(.TICK_DIV(TD), .STABLE_COUNT(SC)) u_dut_a (
    .clk(clk), .rst(rst), .data_in(din_a),
    .data(data_a), .valid(valid_a), .changed(changed_a)
  );

  input_debounce_8ch #(.TICK_DIV(1), .STABLE_COUNT(1)) u_dut_b (
    .clk(clk), .rst(rst), .data_in(din_b),
    .data(data_b), .valid(valid_b), .changed(changed_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Edges since reset release; tick edges of instance A are multiples of TD.
  always @(posedge clk or posedge rst) begin
    if (rst) cyc <= 0;
    else     cyc <= cyc + 1;
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s at edge %0d: got 0x%0h expected 0x%0h", name, cyc, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic int next_tick(input int e);
    return ((e + TD - 1) / TD) * TD;
  endfunction

  vec_t vecs[12];

  initial begin
    int pulses;
    int first;
    int start;
    int exp_edge;
    logic [7:0] hv[32];

    checks = 0;
    errors = 0;
    rst    = 1'b1;
    din_a  = 8'h00;
    din_b  = 8'h00;

    vecs[0]  = '{8'h80, 30, 8'h80, 1};
    vecs[1]  = '{8'h00, 30, 8'h00, 1};
    vecs[2]  = '{8'h04,  6, 8'h00, 0};
    vecs[3]  = '{8'h00, 20, 8'h00, 0};
    vecs[4]  = '{8'h51, 30, 8'h51, 1};
    vecs[5]  = '{8'h00, 30, 8'h00, 1};
    vecs[6]  = '{8'h0F,  7, 8'h00, 0};
    vecs[7]  = '{8'h00, 20, 8'h00, 0};
    vecs[8]  = '{8'hFF, 30, 8'hFF, 1};
    vecs[9]  = '{8'h7F, 30, 8'h7F, 1};
    vecs[10] = '{8'h7E, 30, 8'h7E, 1};
    vecs[11] = '{8'h00, 30, 8'h00, 1};

    // Reset state and settle window.
    repeat (2) step();
    chk("rst_data", 32'(data_a), 0);
    chk("rst_valid", 32'(valid_a), 0);
    chk("rst_changed", 32'(changed_a), 0);
    chk("rst_valid_b", 32'(valid_b), 0);
    rst = 1'b0;
    for (int k = 1; k <= 14; k++) begin
      step();
      chk("settle_valid", 32'(valid_a), (cyc >= TD * SC) ? 1 : 0);
      chk("settle_data", 32'(data_a), 0);
      chk("settle_changed", 32'(changed_a), 0);
      chk("settle_valid_b", 32'(valid_b), 1);
    end

    // Table of held input patterns.
    for (int v = 0; v < 12; v++) begin
      start  = cyc;
      din_a  = vecs[v].din;
      pulses = 0;
      first  = -1;
      for (int h = 0; h < vecs[v].hold; h++) begin
        step();
        if (changed_a) begin
          pulses++;
          if (first < 0) first = cyc;
        end
      end
      chk($sformatf("vec%0d_data", v), 32'(data_a), 32'(vecs[v].exp_data));
      chk($sformatf("vec%0d_pulses", v), pulses, vecs[v].exp_pulses);
      if (vecs[v].exp_pulses == 1) begin
        exp_edge = next_tick(start + 3) + (SC - 1) * TD;
        chk($sformatf("vec%0d_edge", v), first, exp_edge);
        chk($sformatf("vec%0d_latency_ok", v),
            ((first - start) >= 11 && (first - start) <= 15) ? 1 : 0, 1);
      end
    end

    // Bounce on bit 3, aligned so the divider phase is known.
    while ((cyc % TD) != 0) step();
    pulses = 0;
    for (int s = 0; s < 8; s++) begin
      din_a = (s % 2 == 0) ? 8'h08 : 8'h00;
      repeat (3) begin
        step();
        if (changed_a) pulses++;
      end
    end
    chk("bounce_pulses", pulses, 0);
    chk("bounce_data", 32'(data_a), 0);
    start  = cyc;
    din_a  = 8'h08;
    pulses = 0;
    first  = -1;
    repeat (30) begin
      step();
      if (changed_a) begin
        pulses++;
        if (first < 0) first = cyc;
      end
    end
    chk("bounce_final_data", 32'(data_a), 32'(8'h08));
    chk("bounce_final_pulses", pulses, 1);
    chk("bounce_final_edge", first, next_tick(start + 3) + (SC - 1) * TD);
    chk("bounce_latency_ok", ((first - start) <= 15) ? 1 : 0, 1);

    // Mid-debounce reset discards partial counts.
    din_a = 8'h00;
    repeat (30) step();
    chk("pre_mid_data", 32'(data_a), 0);
    din_a = 8'hFF;
    repeat (9) step();
    chk("mid_before_rst_data", 32'(data_a), 0);
    chk("mid_before_rst_valid", 32'(valid_a), 1);
    rst = 1'b1;
    #1;
    chk("mid_rst_data", 32'(data_a), 0);
    chk("mid_rst_valid", 32'(valid_a), 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    for (int k = 1; k <= 14; k++) begin
      step();
      chk("mid_data", 32'(data_a), (cyc >= 12) ? 32'(8'hFF) : 0);
      chk("mid_valid", 32'(valid_a), (cyc >= 12) ? 1 : 0);
      chk("mid_changed", 32'(changed_a), (cyc == 12) ? 1 : 0);
    end

    // TICK_DIV=1, STABLE_COUNT=1 instance follows input with 3 edges of latency.
    hv[0] = 8'h00;
    hv[1] = 8'h00;
    for (int k = 0; k < 26; k++) begin
      hv[k + 2] = ((k % 5) == 4) ? hv[k + 1] : 8'($urandom);
      din_b = hv[k + 2];
      step();
      chk("b_data", 32'(data_b), 32'(hv[k]));
      chk("b_changed", 32'(changed_b), (k > 0 && hv[k] != hv[k - 1]) ? 1 : 0);
    end
    chk("b_valid", 32'(valid_b), 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
